// File: rtl/sisc_pkg.sv
// Shared SISC definitions: owner codes, arbiter states, default widths.
package sisc_pkg;

  localparam int SISC_AW = 16;
  localparam int SISC_DW = 32;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_DM   = 2'd2;
  localparam logic [1:0] OWN_DBG  = 2'd3;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_ACCESS = 2'd1;
  localparam logic [1:0] ARB_RESP   = 2'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority picker: DM > IF > DBG, unless DBG is starved.
module mem_arb_pick
  import sisc_pkg::*;
(
  input  logic       if_req,
  input  logic       dm_req,
  input  logic       dbg_req,
  input  logic       starve,
  output logic [1:0] owner
);

  logic force_dbg;

  assign force_dbg = starve & dbg_req;

  // terms are made mutually exclusive so the decode stays unique
  always_comb begin
    owner = OWN_NONE;
    unique case (1'b1)
      force_dbg:
        owner = OWN_DBG;
      !force_dbg & dm_req:
        owner = OWN_DM;
      !force_dbg & !dm_req & if_req:
        owner = OWN_IF;
      !force_dbg & !dm_req & !if_req & dbg_req:
        owner = OWN_DBG;
      default:
        owner = OWN_NONE;
    endcase
  end

endmodule

// File: rtl/mem_arb.sv
// Single-port memory arbiter for IF, DM and DBG requesters.
module mem_arb
  import sisc_pkg::*;
#(
  parameter int AW      = SISC_AW,
  parameter int DW      = SISC_DW,
  parameter int STARVE  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic [1:0]    owner,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    state;
  logic [2:0]    dbg_wait;
  logic [TW-1:0] tcnt;
  logic [1:0]    pick;
  logic          starve;
  logic          tmo;
  logic          idle;

  assign idle   = state == ARB_IDLE;
  assign starve = dbg_wait == 3'(STARVE);
  assign tmo    = tcnt == TW'(TIMEOUT - 1);

  mem_arb_pick u_pick (
    .if_req  (if_req),
    .dm_req  (dm_req),
    .dbg_req (dbg_req),
    .starve  (starve),
    .owner   (pick)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state     <= ARB_IDLE;
      tcnt      <= '0;
      owner     <= OWN_NONE;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      dbg_ack   <= 1'b0;
    end else begin
      if_ack  <= 1'b0;
      dm_ack  <= 1'b0;
      dbg_ack <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (pick != OWN_NONE) begin
            state  <= ARB_ACCESS;
            busy   <= 1'b1;
            mem_en <= 1'b1;
            owner  <= pick;
            tcnt   <= '0;
            err    <= 1'b0;
            unique case (pick)
              OWN_DM: begin
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
              end
              OWN_DBG: begin
                mem_we    <= dbg_we;
                mem_addr  <= dbg_addr;
                mem_wdata <= dbg_wdata;
              end
              default: begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
              end
            endcase
          end
        end
        ARB_ACCESS: begin
          if (mem_rdy || tmo) begin
            state  <= ARB_RESP;
            mem_en <= 1'b0;
            err    <= !mem_rdy;
            if (!mem_rdy)
              rdata <= '0;
            else if (!mem_we)
              rdata <= mem_rdata;
            if_ack  <= owner == OWN_IF;
            dm_ack  <= owner == OWN_DM;
            dbg_ack <= owner == OWN_DBG;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ARB_RESP: begin
          state  <= ARB_IDLE;
          busy   <= 1'b0;
          owner  <= OWN_NONE;
          err    <= 1'b0;
          mem_we <= 1'b0;
        end
        default: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // losses only count while DBG keeps asking; any gap forgives them
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)
      dbg_wait <= '0;
    else if (!dbg_req)
      dbg_wait <= '0;
    else if (idle && pick == OWN_DBG)
      dbg_wait <= '0;
    else if (idle && (pick == OWN_IF || pick == OWN_DM)
             && dbg_wait != 3'd7)
      dbg_wait <= dbg_wait + 3'd1;
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        if_req, dm_req, dm_we, dbg_req, dbg_we;
  logic [15:0] if_addr, dm_addr, dbg_addr;
  logic [31:0] dm_wdata, dbg_wdata;
  logic        if_ack, dm_ack, dbg_ack;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  owner;
  logic        busy, mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_rdy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arb dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .rdata     (rdata),
    .err       (err),
    .owner     (owner),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_f     = 1'b0;
    if_req    = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dbg_req   = 1'b0;
    dbg_we    = 1'b0;
    if_addr   = '0;
    dm_addr   = '0;
    dbg_addr  = '0;
    dm_wdata  = '0;
    dbg_wdata = '0;
    mem_rdata = '0;
    mem_rdy   = 1'b0;
    tick();
    tick();
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_rdata", rdata, 0);
    rst_f = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 0);

    // zero-wait fetch
    if_req    = 1'b1;
    if_addr   = 16'h0010;
    mem_rdy   = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    check("zw_mem_en", 32'(mem_en), 1);
    check("zw_mem_addr", 32'(mem_addr), 32'h0010);
    check("zw_owner", 32'(owner), 1);
    check("zw_ack_early", 32'(if_ack), 0);
    tick();
    check("zw_if_ack", 32'(if_ack), 1);
    check("zw_rdata", rdata, 32'h1234_5678);
    check("zw_err", 32'(err), 0);
    check("zw_resp_en", 32'(mem_en), 0);
    if_req = 1'b0;
    tick();
    check("zw_ack_drop", 32'(if_ack), 0);
    check("zw_owner_clr", 32'(owner), 0);
    check("zw_busy_clr", 32'(busy), 0);

    // DM beats IF; DM write keeps rdata
    if_req    = 1'b1;
    if_addr   = 16'h0044;
    dm_req    = 1'b1;
    dm_we     = 1'b1;
    dm_addr   = 16'h0020;
    dm_wdata  = 32'hDEAD_BEEF;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    check("pr_owner_dm", 32'(owner), 2);
    check("pr_mem_we", 32'(mem_we), 1);
    check("pr_mem_addr", 32'(mem_addr), 32'h0020);
    check("pr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    check("pr_dm_ack", 32'(dm_ack), 1);
    check("pr_if_noack", 32'(if_ack), 0);
    check("pr_wr_hold", rdata, 32'h1234_5678);
    dm_req = 1'b0;
    dm_we  = 1'b0;
    tick();
    check("pr_idle", 32'(owner), 0);
    tick();
    check("pr_owner_if", 32'(owner), 1);
    check("pr_if_addr", 32'(mem_addr), 32'h0044);
    check("pr_if_we", 32'(mem_we), 0);
    tick();
    check("pr_if_ack", 32'(if_ack), 1);
    check("pr_if_rdata", rdata, 32'hCAFE_F00D);
    if_req = 1'b0;
    tick();

    // starvation: DBG forced in after four lost grants
    dbg_req   = 1'b1;
    dbg_addr  = 16'h0300;
    mem_rdata = 32'h0000_0D8D;
    for (int i = 0; i < 5; i++) begin
      dm_req = (i % 2 == 0);
      dm_addr = 16'h0100;
      if_req = (i % 2 == 1) || (i == 4);
      if_addr = 16'h0200;
      tick();
      if (i < 4) begin
        check($sformatf("st_owner%0d", i), 32'(owner),
              (i % 2 == 0) ? 2 : 1);
        check($sformatf("st_wait%0d", i), 32'(dut.dbg_wait), i + 1);
      end else begin
        check("st_owner_dbg", 32'(owner), 3);
        check("st_dbg_addr", 32'(mem_addr), 32'h0300);
        check("st_wait_clr", 32'(dut.dbg_wait), 0);
      end
      tick();
      if (i < 4)
        check($sformatf("st_ack%0d", i), 32'(if_ack | dm_ack), 1);
      else
        check("st_dbg_ack", 32'(dbg_ack), 1);
      if_req = 1'b0;
      dm_req = 1'b0;
      if (i == 4)
        dbg_req = 1'b0;
      tick();
    end

    // three wait states on a read
    if_req    = 1'b1;
    if_addr   = 16'h0050;
    mem_rdy   = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    tick();
    tick();
    tick();
    tick();
    check("ws_no_ack", 32'(if_ack), 0);
    check("ws_busy", 32'(busy), 1);
    mem_rdy   = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_rdata = 32'hFFFF_FFFF;
    check("ws_if_ack", 32'(if_ack), 1);
    check("ws_rdata", rdata, 32'h0BAD_F00D);
    if_req = 1'b0;
    tick();

    // timeout
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 16'h0060;
    mem_rdy = 1'b0;
    for (int c = 1; c <= 15; c++)
      tick();
    check("to_no_ack15", 32'(dm_ack), 0);
    check("to_busy15", 32'(mem_en), 1);
    tick();
    check("to_dm_ack", 32'(dm_ack), 1);
    check("to_err", 32'(err), 1);
    check("to_rdata", rdata, 0);
    dm_req = 1'b0;
    tick();
    check("to_err_clr", 32'(err), 0);
    dm_req    = 1'b1;
    mem_rdy   = 1'b1;
    mem_rdata = 32'h55AA_55AA;
    tick();
    tick();
    check("to_next_ack", 32'(dm_ack), 1);
    check("to_next_err", 32'(err), 0);
    check("to_next_rdata", rdata, 32'h55AA_55AA);
    dm_req = 1'b0;
    tick();

    // reset in the middle of an access
    if_req  = 1'b1;
    if_addr = 16'h0070;
    mem_rdy = 1'b0;
    tick();
    check("rm_pre_en", 32'(mem_en), 1);
    rst_f = 1'b0;
    #1;
    check("rm_mem_en", 32'(mem_en), 0);
    check("rm_busy", 32'(busy), 0);
    check("rm_owner", 32'(owner), 0);
    check("rm_rdata", rdata, 0);
    tick();
    check("rm_no_ack", 32'(if_ack), 0);
    rst_f     = 1'b1;
    mem_rdy   = 1'b1;
    mem_rdata = 32'h1357_9BDF;
    tick();
    check("rm_regrant", 32'(owner), 1);
    check("rm_addr", 32'(mem_addr), 32'h0070);
    tick();
    check("rm_if_ack", 32'(if_ack), 1);
    check("rm_rdata2", rdata, 32'h1357_9BDF);
    if_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Single-port memory arbiter for the SISC core. It shares one memory port between three requesters: instruction fetch (IF), data load/store (DM) and the debug/program loader (DBG). It sits between `ctrl`/datapath and the unified memory, and sequences each access through a request/acknowledge handshake. Memory latency is variable, there is a timeout, and a starvation guard protects the debug port.

## Interface
- `AW`, 16, address width
- `DW`, 32, data width
- `STARVE`, 4, grants lost by a waiting DBG request before DBG is forced to win
- `TIMEOUT`, 15, ACCESS cycles without `mem_rdy` before the access is aborted
- `clk` in 1: sole clock, rising edge
- `rst_f` in 1: reset, asynchronous, active-low
- `if_req` in 1, `if_addr` in AW: fetch read request
- `if_ack` out 1: one-cycle fetch completion pulse
- `dm_req` in 1, `dm_we` in 1, `dm_addr` in AW, `dm_wdata` in DW: data request
- `dm_ack` out 1: one-cycle data completion pulse
- `dbg_req` in 1, `dbg_we` in 1, `dbg_addr` in AW, `dbg_wdata` in DW: debug request
- `dbg_ack` out 1: one-cycle debug completion pulse
- `rdata` out DW: read data, valid in the ack cycle
- `err` out 1: high with ack when the access timed out
- `owner` out 2: current grant (0 none, 1 IF, 2 DM, 3 DBG)
- `busy` out 1: high whenever state ≠ IDLE
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out AW, `mem_wdata` out DW: memory command
- `mem_rdata` in DW, `mem_rdy` in 1: memory response; `mem_rdy` marks the completing cycle

## Operation
- **FSM states:** IDLE → ACCESS → RESP → IDLE.
- **IDLE:**
  - Sample requests and pick a winner.
  - Register `owner`, command fields and `mem_we`.
  - With no request, stay in IDLE.
- **Priority:** DM > IF > DBG. Exception: if `dbg_wait == STARVE` and `dbg_req` is high, DBG wins.
- **`dbg_wait` (3 bits, saturating):**
  - Increments on each IF/DM grant while `dbg_req` is high.
  - Clears on a DBG grant or when `dbg_req` is low.
- **ACCESS:**
  - `mem_en=1`; address, write data and `mem_we` are held stable from the granted requester.
  - `tcnt` clears on entry and increments each cycle.
  - `mem_rdy=1` → RESP with `err=0`. On a read, `mem_rdata` is captured into `rdata`.
  - `tcnt == TIMEOUT-1` without `mem_rdy` → RESP with `err=1` and `rdata=0`.
- **RESP:**
  - The ack of the owner is high for exactly one cycle; `err` is valid.
  - `mem_en=0`.
  - Next state is IDLE and `owner` returns to 0.
- **Writes:** `rdata` holds its previous value on successful writes.
- **Requester rules:**
  - Hold req and all fields stable until ack; drop req on the edge ending the ack cycle.
  - A req withdrawn mid-access is illegal. The access completes and the ack still pulses.
- **Simultaneous requests:** one grant per transaction; losers wait with no ack.
- **Reset (any state, including mid-access):**
  - All outputs go to 0 immediately: `mem_en`, acks, `err`, `busy`, `owner`, `rdata`.
  - State goes to IDLE; `dbg_wait` and `tcnt` clear.
  - No ack is produced for the interrupted access.

## Timing
- **Zero-wait memory** (`mem_rdy` high in the first ACCESS cycle): req seen in IDLE at cycle 0, `mem_en` at cycle 1, ack at cycle 2. Transaction spacing is 3 cycles.
- **Wait states:** N wait states add N cycles.
- **Timeout:** ack with `err` arrives TIMEOUT+1 cycles after the grant.
- **Outputs:** all are registered; none depends combinationally on inputs.
- **`mem_rdy`:** ignored outside ACCESS.

## Structure
- **Shared `sisc_pkg` contents:**
  - Owner encodings `OWN_NONE`/`OWN_IF`/`OWN_DM`/`OWN_DBG`.
  - Arbiter state constants `ARB_IDLE`/`ARB_ACCESS`/`ARB_RESP`.
  - Default `AW`/`DW`.
- **Sub-module:** `mem_arb_pick`, a combinational priority picker taking the three reqs and the starvation flag and returning the owner code. Everything else stays in `mem_arb`.

## Test plan
- **Zero-wait fetch:** `if_req=1`, `if_addr=0x0010`, `mem_rdy` tied high, `mem_rdata=0x12345678` → `mem_en` at cycle 1 with `mem_addr=0x0010`; `if_ack` at cycle 2 with `rdata=0x12345678`, `err=0`.
- **Priority:** `if_req` and `dm_req` (`dm_we=1`, addr `0x0020`, wdata `0xDEADBEEF`) raised together → DM granted first (`owner=2`, `mem_we=1`); IF granted after the `dm_ack` cycle.
- **Starvation:** `dbg_req` held while IF and DM alternate continuously → DBG granted after exactly 4 lost grants (`owner=3`); `dbg_wait` clears afterwards.
- **Wait states:** `mem_rdy` delayed 3 cycles on a read → ack at cycle 5 with the data present when `mem_rdy` rose.
- **Timeout:** `mem_rdy` never asserted → ack with `err=1`, `rdata=0` at cycle 16 after the grant; next request is served normally.
- **Reset mid-access:** `rst_f` pulled low during ACCESS → `mem_en`, `busy`, `owner` drop asynchronously, no ack; after release, a pending `if_req` completes normally.
